// File: rtl/piso_unit.sv
// piso_unit - transmit end of the 8-bit serial shift link.
//
// Takes a WIDTH-bit word over a valid/ready handshake and shifts it out
// MSB first, one bit per clk, with a qualifying valid strobe. The first bit
// sent lands in the top bit of the receiving SIPO, so after WIDTH shifts the
// receiver holds the word in its original bit positions.
//
// Optional feature (macro PISO_PARITY_EN): when defined, one extra cycle
// after data_in[0] carries the even-parity bit (XOR of the accepted word).
// The frame is then WIDTH+1 cycles long, and done/load_ready align to the
// parity cycle. When the macro is undefined, frames are WIDTH cycles long.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   data_in      parallel word, sampled only on the accept edge
//   load_valid   upstream presents a word on data_in
//   load_ready   block can accept a word this cycle (combinational)
//   serial_out   registered serial data bit
//   serial_valid registered, high while serial_out carries a frame bit
//   done         registered, one-cycle pulse on the last bit of a frame
//
// state | meaning
// IDLE  | no frame in flight, outputs at 0
// SHIFT | serial_out carries frame bit number cnt

module piso_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             so_nx, sv_nx, done_nx;
  logic             last, accept;
`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] DATA_END = CW'(WIDTH - 1);
  logic             par, par_nx;
`endif

  always_comb begin
    last       = (state == SHIFT) && (cnt == LAST_CNT);
    load_ready = !rst && ((state == IDLE) || last);
    accept     = load_valid && load_ready;

    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    so_nx    = 1'b0;
    sv_nx    = 1'b0;
    done_nx  = 1'b0;
`ifdef PISO_PARITY_EN
    par_nx   = par;
`endif

    if (accept) begin
      state_nx = SHIFT;
      shreg_nx = data_in;
      cnt_nx   = '0;
      so_nx    = data_in[WIDTH-1];
      sv_nx    = 1'b1;
`ifdef PISO_PARITY_EN
      // Parity is frozen at accept so later data_in changes cannot affect it.
      par_nx   = ^data_in;
`endif
    end else if (state == SHIFT && !last) begin
      cnt_nx   = cnt + CW'(1);
      // shreg keeps the bit currently on serial_out at its top; the next bit
      // to present is therefore one position below.
      shreg_nx = shreg << 1;
      sv_nx    = 1'b1;
      done_nx  = ((cnt + CW'(1)) == LAST_CNT);
`ifdef PISO_PARITY_EN
      so_nx    = (cnt == DATA_END) ? par : shreg[WIDTH-2];
`else
      so_nx    = shreg[WIDTH-2];
`endif
    end else if (last) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      done         <= 1'b0;
`ifdef PISO_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      shreg        <= shreg_nx;
      cnt          <= cnt_nx;
      serial_out   <= so_nx;
      serial_valid <= sv_nx;
      done         <= done_nx;
`ifdef PISO_PARITY_EN
      par          <= par_nx;
`endif
    end
  end

endmodule

// File: tb/tb_piso_unit.sv
module tb_piso_unit;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  piso_unit #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .done         (done)
  );

  always #5 clk = ~clk;

  // word, then the hand-written frame: 8 data bits MSB first, then parity
  typedef struct {
    logic [7:0] word;
    logic [8:0] frame;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bit i of a frame for word w (MSB first, parity after data).
  function automatic logic exp_bit(input logic [7:0] w, input int i);
    if (i < WIDTH) return w[WIDTH-1-i];
    return ^w;
  endfunction

  // Expects the bench to be 1 time unit after a posedge with the DUT idle.
  task automatic send_frame(input logic [7:0] w, input logic [8:0] frame);
    logic [7:0] sipo;
    sipo = '0;
    data_in    = w;
    load_valid = 1'b1;
    #1;
    chk("accept_ready", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    data_in    = ~w;
    for (int i = 0; i < FL; i++) begin
      #1;
      chk($sformatf("bit%0d_w%02h", i, w), 32'(serial_out), 32'(frame[8-i]));
      chk("frame_valid", 32'(serial_valid), 32'd1);
      chk("frame_done", 32'(done), 32'(i == FL - 1));
      chk("frame_ready", 32'(load_ready), 32'(i == FL - 1));
      if (serial_valid && i < WIDTH) sipo = {sipo[6:0], serial_out};
      tick();
    end
    chk($sformatf("sipo_w%02h", w), 32'(sipo), 32'(w));
    chk("post_valid", 32'(serial_valid), 32'd0);
    chk("post_out", 32'(serial_out), 32'd0);
    chk("post_done", 32'(done), 32'd0);
  endtask

  // Frame w1 is accepted; w2 is offered from bit k of that frame on and must
  // be taken on the last-bit cycle, following with no gap.
  task automatic two_frames(input logic [7:0] w1, input logic [7:0] w2, input int k);
    logic [7:0] w;
    int         i;
    data_in    = w1;
    load_valid = 1'b1;
    #1;
    chk("b2b_ready0", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    data_in    = 8'h00;
    for (int c = 0; c < 2 * FL; c++) begin
      i = c % FL;
      w = (c < FL) ? w1 : w2;
      if (c == k) begin
        load_valid = 1'b1;
        data_in    = w2;
      end
      if (c == FL) begin
        load_valid = 1'b0;
        data_in    = ~w2;
      end
      #1;
      chk($sformatf("b2b_bit%0d", c), 32'(serial_out), 32'(exp_bit(w, i)));
      chk("b2b_valid", 32'(serial_valid), 32'd1);
      chk("b2b_done", 32'(done), 32'(i == FL - 1));
      chk("b2b_ready", 32'(load_ready), 32'(i == FL - 1));
      tick();
    end
    chk("b2b_idle", 32'(serial_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 9'b1010_0101_0};
    vecs[1] = '{8'h3C, 9'b0011_1100_0};
    vecs[2] = '{8'h81, 9'b1000_0001_0};
    vecs[3] = '{8'h07, 9'b0000_0111_1};
    vecs[4] = '{8'h03, 9'b0000_0011_0};
    vecs[5] = '{8'hFF, 9'b1111_1111_0};
    vecs[6] = '{8'h01, 9'b0000_0001_1};
    vecs[7] = '{8'hC3, 9'b1100_0011_0};

    // reset with load_valid held: nothing accepted, not ready
    rst        = 1'b1;
    load_valid = 1'b1;
    data_in    = 8'hFF;
    tick();
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_valid", 32'(serial_valid), 32'd0);
    tick();
    chk("rst_ready2", 32'(load_ready), 32'd0);
    chk("rst_out", 32'(serial_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst        = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("idle_ready", 32'(load_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_hold", 32'({serial_out, serial_valid, done}), 32'd0);
    end

    // table of single frames
    for (int v = 0; v < 8; v++) send_frame(vecs[v].word, vecs[v].frame);

    // back-to-back, second word held from the first cycle
    two_frames(8'h3C, 8'hC3, 0);

    // stall: second word offered from bit 3, waits for last-bit cycle
    two_frames(8'h0F, 8'h55, 3);

    // reset mid-frame
    data_in    = 8'hF0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mid_bit", 32'(serial_out), 32'd1);
      if (i < 2) tick();
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(load_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("mid_rst_out", 32'({serial_out, serial_valid, done}), 32'd0);
    for (int c = 0; c < FL + 2; c++) begin
      tick();
      chk("mid_no_done", 32'({serial_valid, done}), 32'd0);
    end
    send_frame(8'h81, 9'b1000_0001_0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
